// File: rtl/eth_tx_stager_pkg.sv
// ---------------------------------------------------------------------------
// eth_tx_stager_pkg
// Shared definitions for the Ethernet transmit staging block:
//   - sender FSM state encodings
//   - CPU register addresses decoded upstream into the two store strobes
//   - status word bit positions
//   - default minimum frame payload and commit length field width
// ---------------------------------------------------------------------------
package eth_tx_stager_pkg;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_SEND = 2'd1,
    ST_PAD  = 2'd2
  } state_e;

  // Store addresses that the upstream decoder turns into our strobes.
  localparam logic [11:0] ADDR_SEND_ENA  = 12'h82C;
  localparam logic [11:0] ADDR_SEND_DATA = 12'h830;

  // Status word layout: {busy, err, ovf, 13'b0, byte_cnt[15:0]}
  localparam int STAT_BUSY = 31;
  localparam int STAT_ERR  = 30;
  localparam int STAT_OVF  = 29;

  localparam int MIN_BYTES_DEFAULT = 60;

  // Commit length field is wdata[10:0].
  localparam int LEN_W = 11;

endpackage

// File: rtl/eth_tx_ram.sv
// ---------------------------------------------------------------------------
// eth_tx_ram
// Simple dual-port frame staging RAM, DEPTH_WORDS x 32, synchronous read.
// Ports:
//   clk    in   clock
//   we     in   write enable (CPU side)
//   waddr  in   write word address
//   wdata  in   write data
//   raddr  in   read word address (sender side)
//   rdata  out  registered read data, valid one cycle after raddr
// No reset on the array or read register so it maps onto block RAM.
// ---------------------------------------------------------------------------
module eth_tx_ram #(
  parameter int DEPTH_WORDS = 384,
  parameter int AW          = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/eth_tx_stager.sv
// ---------------------------------------------------------------------------
// eth_tx_stager
// Buffers CPU data words into a staging RAM, then on commit streams the frame
// byte-serially (big-endian within each word) to the NIC over valid/ready,
// zero-padding short frames to MIN_BYTES.
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   wdata         in   CPU store data
//   send_data_we  in   data word push strobe
//   send_ena_we   in   commit strobe, wdata[10:0] = frame length in bytes
//   tx_data       out  byte to NIC
//   tx_valid      out  tx_data valid
//   tx_last       out  final byte of frame (qualified by tx_valid)
//   tx_ready      in   NIC accepts byte on tx_valid & tx_ready
//   status        out  {busy, err, ovf, 13'b0, byte_cnt[15:0]}
// ---------------------------------------------------------------------------
module eth_tx_stager
  import eth_tx_stager_pkg::*;
#(
  parameter int DEPTH_WORDS = 384,
  parameter int AW          = 9,
  parameter int MIN_BYTES   = MIN_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] wdata,
  input  logic        send_data_we,
  input  logic        send_ena_we,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        tx_last,
  input  logic        tx_ready,
  output logic [31:0] status
);

  state_e           state_q;
  logic [AW:0]      wr_ptr_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] fetch_idx_q;
  logic [LEN_W-1:0] fetch_idx_d;
  logic             busy_q;
  logic             err_q;
  logic             ovf_q;
  logic             prime_q;
  logic             tx_valid_q;
  logic             tx_last_q;
  logic [7:0]       tx_data_q;

  logic [15:0]      byte_cnt;
  logic             wr_full;
  logic             ram_we;
  logic [LEN_W-1:0] commit_len;
  logic             len_ok;
  logic [LEN_W-1:0] total_len;
  logic             advance;
  logic             load;
  logic             hs;
  logic [LEN_W-3:0] rd_word_idx;
  logic [AW-1:0]    rd_addr;
  logic [31:0]      rd_word;
  logic [7:0]       rd_bytes [4];
  logic [7:0]       next_byte;
  logic [31:0]      status_w;

  // -------------------------------------------------------------------------
  // Staging RAM
  // -------------------------------------------------------------------------
  eth_tx_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (wdata),
    .raddr (rd_addr),
    .rdata (rd_word)
  );

  // Big-endian lane split: byte offset 0 is bits [31:24].
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_bytes[gi] = rd_word[31-8*gi -: 8];
  end

  // -------------------------------------------------------------------------
  // Combinational helpers
  // -------------------------------------------------------------------------
  assign byte_cnt   = 16'({wr_ptr_q, 2'b00});
  assign wr_full    = (wr_ptr_q == (AW+1)'(DEPTH_WORDS));
  assign ram_we     = (state_q == ST_FILL) && send_data_we && !wr_full;
  assign commit_len = wdata[LEN_W-1:0];
  assign len_ok     = (commit_len != '0) && (16'(commit_len) <= byte_cnt);
  assign total_len  = (len_q < LEN_W'(MIN_BYTES)) ? LEN_W'(MIN_BYTES) : len_q;

  // The output register may take a new byte when empty or being drained.
  assign advance = !tx_valid_q || tx_ready;
  assign hs      = tx_valid_q && tx_ready;
  assign load    = (state_q != ST_FILL) && !prime_q && advance &&
                   (fetch_idx_q < total_len);

  // Read address is driven from the next fetch index so that rd_word always
  // holds the word containing fetch_idx_q; this keeps the stream bubble-free.
  assign fetch_idx_d = load ? fetch_idx_q + LEN_W'(1) : fetch_idx_q;
  assign rd_word_idx = fetch_idx_d[LEN_W-1:2];
  assign rd_addr     = (32'(rd_word_idx) < DEPTH_WORDS) ? AW'(rd_word_idx) : '0;

  assign next_byte = (fetch_idx_q < len_q) ? rd_bytes[fetch_idx_q[1:0]] : 8'h00;

  // -------------------------------------------------------------------------
  // Control FSM and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      wr_ptr_q    <= '0;
      len_q       <= '0;
      fetch_idx_q <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      prime_q     <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_last_q   <= 1'b0;
      tx_data_q   <= 8'h00;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (send_data_we) begin
            if (wr_full) begin
              ovf_q <= 1'b1;
            end else begin
              wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            // Simultaneous commit loses to the data push.
            if (send_ena_we) begin
              err_q <= 1'b1;
            end
          end else if (send_ena_we) begin
            if (len_ok) begin
              len_q       <= commit_len;
              fetch_idx_q <= '0;
              busy_q      <= 1'b1;
              err_q       <= 1'b0;
              ovf_q       <= 1'b0;
              prime_q     <= 1'b1;
              state_q     <= ST_SEND;
            end else begin
              err_q <= 1'b1;
            end
          end
        end

        ST_SEND, ST_PAD: begin
          if (send_data_we || send_ena_we) begin
            err_q <= 1'b1;
          end
          // One idle cycle lets the first RAM read land before byte 0 loads.
          prime_q <= 1'b0;

          if (load) begin
            tx_data_q   <= next_byte;
            tx_valid_q  <= 1'b1;
            tx_last_q   <= (fetch_idx_q == total_len - LEN_W'(1));
            fetch_idx_q <= fetch_idx_d;
          end else if (advance) begin
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
          end

          // Byte L-1 accepted on a short frame: remaining bytes are padding.
          if (state_q == ST_SEND && hs && !tx_last_q && fetch_idx_q == len_q) begin
            state_q <= ST_PAD;
          end

          if (hs && tx_last_q) begin
            state_q     <= ST_FILL;
            wr_ptr_q    <= '0;
            busy_q      <= 1'b0;
            fetch_idx_q <= '0;
          end
        end

        default: state_q <= ST_FILL;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    status_w            = '0;
    status_w[STAT_BUSY] = busy_q;
    status_w[STAT_ERR]  = err_q;
    status_w[STAT_OVF]  = ovf_q;
    status_w[15:0]      = byte_cnt;
  end

  assign status   = status_w;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign tx_last  = tx_last_q;

endmodule

// File: tb/tb_eth_tx_stager.sv
// ---------------------------------------------------------------------------
// tb_eth_tx_stager
// Directed bench for eth_tx_stager: pushes words, commits frames, collects
// the transmitted byte stream and compares it with expected frames.
// ---------------------------------------------------------------------------
module tb_eth_tx_stager;

  logic        clk;
  logic        rst_n;
  logic [31:0] wdata;
  logic        send_data_we;
  logic        send_ena_we;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_last;
  logic        tx_ready;
  logic [31:0] status;

  eth_tx_stager dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wdata        (wdata),
    .send_data_we (send_data_we),
    .send_ena_we  (send_ena_we),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_last      (tx_last),
    .tx_ready     (tx_ready),
    .status       (status)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Byte collector, sampled on the falling edge.
  logic [7:0] byte_q [$];
  int         nlast     = 0;
  int         lastpos   = -1;
  int         nvalid    = 0;
  int         stall_n   = 0;
  int         stall_bad = 0;
  logic       hold_prev = 1'b0;
  logic [7:0] hold_data = 8'h00;

  initial begin
    forever begin
      @(negedge clk);
      if (hold_prev) begin
        stall_n++;
        if (!tx_valid || tx_data !== hold_data) stall_bad++;
      end
      if (tx_valid) nvalid++;
      if (tx_valid && tx_ready) begin
        byte_q.push_back(tx_data);
        if (tx_last) begin
          nlast++;
          lastpos = byte_q.size() - 1;
        end
      end
      hold_prev = tx_valid && !tx_ready;
      hold_data = tx_data;
    end
  end

  int unsigned wq [$];
  logic [7:0]  exp_q [$];
  int          base_n, base_last, base_valid;

  task automatic mark();
    base_n     = byte_q.size();
    base_last  = nlast;
    base_valid = nvalid;
  endtask

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic push(input logic [31:0] w, input bit rec);
    if (rec) wq.push_back(w);
    wdata        = w;
    send_data_we = 1'b1;
    @(posedge clk); #1;
    send_data_we = 1'b0;
    wdata        = '0;
  endtask

  task automatic commit(input int len);
    wdata       = 32'(len);
    send_ena_we = 1'b1;
    @(posedge clk); #1;
    send_ena_we = 1'b0;
    wdata       = '0;
  endtask

  task automatic build_exp(input int len);
    logic [31:0] w;
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      w = wq[i/4] >> (24 - 8*(i%4));
      exp_q.push_back(w[7:0]);
    end
    while (exp_q.size() < 60) exp_q.push_back(8'h00);
  endtask

  task automatic wait_done(input string tag, input int budget, input bit toggle);
    int c;
    c = 0;
    while (!(nlast > base_last && !status[31]) && c < budget) begin
      @(posedge clk); #1;
      if (toggle) tx_ready = ~tx_ready;
      c++;
    end
    tx_ready = 1'b1;
    chk({tag, "_done"}, 32'(c < budget), 32'd1);
  endtask

  task automatic check_frame(input string tag);
    int n;
    int errs;
    n    = byte_q.size() - base_n;
    errs = 0;
    chk({tag, "_count"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      if (byte_q[base_n + i] !== exp_q[i]) errs++;
    end
    chk({tag, "_data_errs"}, 32'(errs), 32'd0);
    chk({tag, "_last_cnt"}, 32'(nlast - base_last), 32'd1);
    chk({tag, "_last_pos"}, 32'(lastpos - base_n), 32'(exp_q.size() - 1));
  endtask

  initial begin
    int c;
    int sb_n;
    int sb_bad;
    rst_n        = 1'b0;
    wdata        = '0;
    send_data_we = 1'b0;
    send_ena_we  = 1'b0;
    tx_ready     = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_status", status, 32'h0);
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_last", 32'(tx_last), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Short frame, padded to 60 bytes, ready held high.
    wq.delete();
    push(32'h11223344, 1);
    push(32'h55667788, 1);
    chk("t1_fill_status", status, 32'h0000_0008);
    build_exp(8);
    mark();
    commit(8);
    chk("t1_busy", status, 32'h8000_0008);
    chk("t1_lat0", 32'(tx_valid), 32'd0);
    @(posedge clk); #1;
    chk("t1_lat1", 32'(tx_valid), 32'd0);
    @(posedge clk); #1;
    chk("t1_lat2", 32'(tx_valid), 32'd1);
    chk("t1_first", 32'(tx_data), 32'h11);
    wait_done("t1", 300, 0);
    check_frame("t1");
    chk("t1_valid_cycles", 32'(nvalid - base_valid), 32'd60);
    chk("t1_status_end", status, 32'h0);

    // 64-byte frame with ready toggling.
    wq.delete();
    for (int i = 0; i < 16; i++) begin
      push({8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)}, 1);
    end
    build_exp(64);
    sb_n   = stall_n;
    sb_bad = stall_bad;
    mark();
    commit(64);
    wait_done("t2", 2000, 1);
    check_frame("t2");
    chk("t2_hold_errs", 32'(stall_bad - sb_bad), 32'd0);
    chk("t2_hold_seen", 32'((stall_n - sb_n) > 0), 32'd1);
    chk("t2_status_end", status, 32'h0);

    // Commit longer than the buffer is rejected, then a valid retry.
    wq.delete();
    push(32'hA1B2C3D4, 1);
    mark();
    commit(5);
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("t3_no_tx", 32'(nvalid - base_valid), 32'd0);
    chk("t3_status_err", status, 32'h4000_0004);
    push(32'hE5F60718, 1);
    build_exp(5);
    mark();
    commit(5);
    chk("t3_err_clr", status, 32'h8000_0008);
    wait_done("t3", 300, 0);
    check_frame("t3");
    chk("t3_status_end", status, 32'h0);

    // Fill the buffer, overflow it, send a maximal frame.
    wq.delete();
    for (int i = 0; i < 384; i++) begin
      push({16'(i), ~16'(i)}, 1);
    end
    push(32'hFFFF_FFFF, 0);
    chk("t4_ovf", status, 32'h2000_0600);
    build_exp(1536);
    mark();
    commit(1536);
    chk("t4_ovf_clr", status, 32'h8000_0600);
    wait_done("t4", 3000, 0);
    check_frame("t4");
    chk("t4_status_end", status, 32'h0);

    // Strobes while busy are ignored but flagged.
    wq.delete();
    push(32'hCAFEF00D, 1);
    push(32'h01234567, 1);
    build_exp(8);
    mark();
    commit(8);
    repeat (3) begin
      @(posedge clk); #1;
    end
    push(32'hDEADBEEF, 0);
    commit(4);
    chk("t5_err_busy", status, 32'hC000_0008);
    wait_done("t5", 300, 0);
    check_frame("t5");
    chk("t5_status_end", status, 32'h4000_0000);

    // Reset in the middle of a frame, then a clean frame.
    wq.delete();
    for (int i = 0; i < 4; i++) push(32'h10203040 + 32'(i), 1);
    mark();
    commit(16);
    c = 0;
    while ((byte_q.size() - base_n) < 10 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    chk("t6_reach10", 32'((byte_q.size() - base_n) >= 10), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_valid_async", 32'(tx_valid), 32'd0);
    chk("t6_status_rst", status, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    wq.delete();
    push(32'h9A8B7C6D, 1);
    push(32'h5E4F3021, 1);
    build_exp(8);
    mark();
    commit(8);
    wait_done("t6", 300, 0);
    check_frame("t6");
    chk("t6_status_end", status, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/eth_tx_stager.md
Name: eth_tx_stager

Overview:
- Downstream consumer of the store-address decoder's `EthSendData_we` and `EthSendEna_we` strobes.
- CPU `sw` words to 0x830 are buffered into a frame-staging RAM.
- An `sw` to 0x82c commits a frame of a given byte length.
- The block then streams the frame byte-serially to the Ethernet NIC transmit interface over a valid/ready handshake, zero-padding to the minimum Ethernet payload. Status is readable by the CPU load mux.

Parameters:
- DEPTH_WORDS, 384, staging RAM depth in 32-bit words (1536 bytes max frame).
- AW, 9, word address width; requires 2**AW >= DEPTH_WORDS.
- MIN_BYTES, 60, minimum bytes emitted per frame (zero padding; MAC adds FCS).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wdata  in  32  CPU store data, shared bus.
- send_data_we  in  1  store strobe for 0x830 (data word push).
- send_ena_we  in  1  store strobe for 0x82c (commit; `wdata[10:0]` = length L in bytes).
- tx_data  out  8  byte to NIC.
- tx_valid  out  1  `tx_data` valid.
- tx_last  out  1  final byte of frame, qualified by `tx_valid`.
- tx_ready  in  1  NIC accepts byte when `tx_valid & tx_ready`.
- status  out  32  `{busy, err, ovf, 13'b0, byte_cnt[15:0]}`, where `byte_cnt` = words_written*4.

Behaviour:
- Reset (async, `rst_n` low): state=FILL; wr_ptr=0; rd byte index=0; `busy`/`err`/`ovf`=0; `tx_valid`=0; `tx_last`=0; `tx_data`=0.
- Reset mid-frame aborts immediately. `tx_valid` drops asynchronously and the staging RAM contents are discarded.
- States: FILL, SEND, PAD.
- FILL:
  - `send_data_we`: write `wdata` at wr_ptr, wr_ptr+1.
  - If wr_ptr==DEPTH_WORDS: write dropped, `ovf`:=1 (sticky until next successful commit).
  - `send_ena_we` with 1<=L<=wr_ptr*4: latch L, idx:=0, `busy`:=1, `err`:=0, `ovf`:=0, go to SEND.
  - `send_ena_we` with L==0 or L>wr_ptr*4: ignored, `err`:=1, stay in FILL, buffer kept.
  - Both strobes in one cycle cannot occur (single decoder). If both are asserted anyway, the data push wins and the commit is ignored with `err`:=1.
- SEND:
  - Byte order per word is big-endian: byte idx maps to `word[idx>>2]`, bits `[31-8*(idx%4) -: 8]`.
  - RAM is synchronous read with one cycle of prefetch latency. The first `tx_valid` rises 2 cycles after the commit strobe.
  - `tx_data`, `tx_valid`, and `tx_last` are registered and held stable while `!tx_ready`. A bubble-free stream is required: 1 byte/cycle when `tx_ready` is held high.
  - After byte idx==L-1 is accepted:
    - if L<MIN_BYTES, go to PAD;
    - else frame complete.
  - `tx_last` is asserted on byte L-1 only when L>=MIN_BYTES.
- PAD: emit 0x00 bytes until MIN_BYTES total have been accepted. `tx_last` is on the byte with index MIN_BYTES-1.
- Frame complete: wr_ptr:=0, `busy`:=0, go to FILL on the cycle after the last handshake.
- Any `send_data_we` or `send_ena_we` while `busy`: ignored, `err`:=1. The frame in flight is unaffected.
- `byte_cnt` is 16 bits wide; no wrap is possible because DEPTH_WORDS*4 <= 65535.

Decomposition:
- Shared package / header:
  - state encodings (FILL=2'd0, SEND=2'd1, PAD=2'd2);
  - register address constants 0x82C and 0x830;
  - status bit positions;
  - MIN_BYTES default.
- One sub-module: `eth_tx_ram`, a simple dual-port synchronous-read RAM of DEPTH_WORDS x 32 (write port CPU side, read port sender), inferable as BRAM.

Test Plan:
- Push 0x11223344, 0x55667788; commit L=8, `tx_ready`=1.
  - Expect bytes 11 22 33 44 55 66 77 88, then 52 bytes of 00.
  - `tx_last` on byte 60 only; 60 consecutive valid cycles; `busy` returns to 0 and `status[15:0]`=0.
- Push 16 words; commit L=64 with `tx_ready` toggling 1-0-1-0.
  - Exactly 64 bytes, no padding, `tx_last` on byte 64.
  - `tx_data` stable while `tx_ready`=0.
- Push 1 word; commit L=5.
  - Nothing transmitted; `status` = `err`=1, `byte_cnt`=4.
  - Then push 1 word and commit L=5: 5 data bytes + 55 pad bytes, `err` cleared.
- Fill DEPTH_WORDS words, push one more.
  - `ovf`=1, `byte_cnt`=1536.
  - Commit L=1536: the 1536 original bytes are sent, `ovf` cleared.
- During SEND, push 0xDEADBEEF and commit L=4.
  - Both ignored, `err`=1, in-flight frame unchanged.
  - After completion, `byte_cnt`=0.
- Assert `rst_n`=0 mid-SEND at byte 10.
  - `tx_valid`=0 immediately; `status`=0.
  - After release, a new 8-byte frame transmits correctly from byte 0.
